keypad_event_fifo: RTL

Debounces the keypad scanner's key-pressed flag and 4-bit key code, turns each stable press into one event, and queues events in a small first-word-fall-through FIFO. The CPU-side Wishbone wrapper pops events at its own pace. Sits directly downstream of the keypad scanner in the same `clk1` domain; `irq` replaces the scanner's raw level as the CPU interrupt source.

---
 rtl/keypad_pkg.sv | 16 +
 rtl/keypad_sync_fifo.sv | 75 +++++++
 rtl/keypad_event_fifo.sv | 124 ++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad event path.
package keypad_pkg;

  localparam int unsigned KEY_CODE_W = 4;

  // Value presented on the read port when no event is queued.
  localparam logic [KEY_CODE_W-1:0] KEY_NONE = 4'h0;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_e;

endpackage

// File: rtl/keypad_sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through head and drop indication.
module keypad_sync_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk1,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // Accept/drop decisions, storage write and occupancy update.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pop_ok     = pop && !empty;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    push_ok    = push && (!full || pop_ok);
    overflow_c = push && !push_ok;

    if (push_ok) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/keypad_event_fifo.sv
// Debounces scanner key presses into single events and queues them for the CPU.
module keypad_event_fifo
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned DEPTH           = 8
) (
  input  logic                    clk1,
  input  logic                    reset,
  input  logic                    key_valid,
  input  logic [KEY_CODE_W-1:0]   key_code,
  input  logic                    rd_en,
  input  logic                    clr_ovf,
  output logic [KEY_CODE_W-1:0]   rd_data,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    irq
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 2);

  deb_state_e            state_q, state_d;
  logic [DB_W-1:0]       db_cnt_q, db_cnt_d;
  logic [KEY_CODE_W-1:0] code_q, code_d;
  logic                  overflow_q, overflow_d;
  logic                  irq_q, irq_d;
  logic                  push_c;
  logic                  drop_c;
  logic                  fifo_empty;
  logic [KEY_CODE_W-1:0] head_data;

  keypad_sync_fifo #(
    .WIDTH (KEY_CODE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk1       (clk1),
    .reset      (reset),
    .push       (push_c),
    .pop        (rd_en),
    .wr_data    (code_q),
    .head_data  (head_data),
    .count      (count),
    .empty      (fifo_empty),
    .full       (full),
    .overflow_c (drop_c)
  );

  assign empty    = fifo_empty;
  assign rd_data  = fifo_empty ? KEY_NONE : head_data;
  assign overflow = overflow_q;
  assign irq      = irq_q;

  // Debounce next-state: one push per stable press, release must settle before re-arming.
  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    code_d   = code_q;
    push_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (key_valid) begin
          code_d   = key_code;
          db_cnt_d = '0;
          state_d  = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (!key_valid || (key_code != code_q)) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          push_c  = 1'b1;
          state_d = HELD;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      HELD: begin
        // Code changes while held are deliberately ignored.
        if (!key_valid) begin
          db_cnt_d = '0;
          state_d  = RELEASE_WAIT;
        end
      end
      RELEASE_WAIT: begin
        if (key_valid) begin
          state_d = HELD;
        end else if (db_cnt_q == DB_LAST) begin
          state_d = IDLE;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky overflow (a drop beats a clear) and interrupt level.
  always_comb begin
    overflow_d = drop_c | (overflow_q & ~clr_ovf);
    irq_d      = !fifo_empty;
  end

  // Control registers.
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      db_cnt_q   <= '0;
      code_q     <= KEY_NONE;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      code_q     <= code_d;
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
    end
  end

endmodule
